// File: rtl/seq_ctrl_pkg.sv
// Shared constants for the serial pattern detector controller.
//   - ST_* : controller state encoding (IDLE / RUN / DONE)
//   - PAT_W_DEF / CNT_W_DEF : default pattern length and counter width
package seq_ctrl_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/pat_match.sv
// Shift history, fill counter and pattern compare for one detection run.
// Ports:
//   clk, res      : clock, asynchronous active-low reset
//   bit_en        : a bit is accepted at the next rising edge
//   bit_in        : the serial bit being accepted
//   clr           : clear history and fill (start of a new run)
//   ovl           : 1 = overlapping matches, 0 = fill restarts after a match
//   pattern       : pattern to hunt, MSB = first-received bit
//   match         : combinational; the bit being accepted completes a match
module pat_match
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic             clr,
  input  logic             ovl,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_inc;

  // Look one bit ahead: the match is judged on the history as it will be
  // after the accepting edge, so the controller can count it on that edge.
  always_comb begin
    hist_d   = {hist_q[PAT_W-2:0], bit_in};
    fill_inc = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + FW'(1);
    match    = bit_en && (fill_inc == FW'(PAT_W)) && (hist_d == pattern);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_en) begin
      hist_q <= hist_d;
      // Non-overlapping mode: the next match needs PAT_W fresh bits, but the
      // history itself keeps shifting.
      fill_q <= (match && !ovl) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-controlled programmable serial pattern detector.
// A host starts a run (pattern / overlap mode / match target latched at
// start), the block hunts the serial stream, pulses y per match and ends
// the run when the target is reached (done pulse) or on abort.
// Handshake: a serial bit is consumed on a rising edge where a_vld=1 while
// the controller is in RUN and abort=0; there is no back-pressure, a_vld in
// any other state is simply dropped.
// Ports:
//   clk, res     : clock, asynchronous active-low reset
//   start        : begin a run (IDLE only)
//   abort        : end the run immediately (RUN only), beats a same-edge match
//   cfg_pattern  : pattern, MSB first-received; cfg_overlap; cfg_target (0 = unlimited)
//   a, a_vld     : serial data bit and its valid
//   y            : one-cycle match pulse, one cycle after the accepting edge
//   busy         : high in RUN
//   done         : one-cycle pulse when the target was reached
//   match_cnt    : matches in the current or last run (saturating)
//   dbg_state    : controller state (ST_IDLE / ST_RUN / ST_DONE)
module seq_det_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             a,
  input  logic             a_vld,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       dbg_state
);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             y_q;

  logic accept, run_start, match, hit_target;

  always_comb begin
    accept     = (state_q == ST_RUN) && a_vld && !abort;
    run_start  = (state_q == ST_IDLE) && start;
    hit_target = (tgt_q != '0) && ((cnt_q + CNT_W'(1)) == tgt_q);
  end

  pat_match #(
    .PAT_W (PAT_W)
  ) u_pat_match (
    .clk     (clk),
    .res     (res),
    .bit_en  (accept),
    .bit_in  (a),
    .clr     (run_start),
    .ovl     (ovl_q),
    .pattern (pat_q),
    .match   (match)
  );

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; match already excludes abort through accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)                    state_d = ST_IDLE;
        else if (match && hit_target) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration latch, match counter and registered match pulse.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pat_q <= '0;
      ovl_q <= 1'b0;
      tgt_q <= '0;
      cnt_q <= '0;
      y_q   <= 1'b0;
    end else begin
      y_q <= match;
      if (run_start) begin
        pat_q <= cfg_pattern;
        ovl_q <= cfg_overlap;
        tgt_q <= cfg_target;
        cnt_q <= '0;
      end else if (match && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
    y         = y_q;
    match_cnt = cnt_q;
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             res;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             a;
  logic             a_vld;
  logic             y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       dbg_state;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .res         (res),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .a           (a),
    .a_vld       (a_vld),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .match_cnt   (match_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: accepted-bit indices after which a y pulse is expected.
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // Keeps every accepted bit of the run and judges matches on the window of
  // the last PAT_W bits; non-overlap means a new match may not reuse any bit
  // of the previous one.
  bit               m_run, m_done, m_y;
  int               m_cnt;
  int               m_bits[$];
  int               m_last;
  logic [PAT_W-1:0] m_pat;
  bit               m_ovl;
  int               m_tgt;

  function automatic bit window_hit();
    int n = m_bits.size();
    if (n < PAT_W) return 1'b0;
    for (int k = 0; k < PAT_W; k++)
      if (m_bits[n-PAT_W+k] != int'(m_pat[PAT_W-1-k])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_y = 0; m_cnt = 0; m_last = 0;
    m_bits.delete(); m_pat = '0; m_ovl = 0; m_tgt = 0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit ai, input bit av);
    bit ny = 0;
    bit nd = 0;
    int n;
    if (m_done) begin
      // one DONE cycle, then back to idle; start ignored
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_pat = cfg_pattern; m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
        m_bits.delete(); m_last = 0; m_cnt = 0;
      end
    end else if (ab) begin
      m_run = 0;
    end else if (av) begin
      m_bits.push_back(int'(ai));
      n = m_bits.size();
      if (window_hit() && (m_ovl || (n - m_last >= PAT_W))) begin
        ny = 1; m_last = n;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_tgt != 0 && m_cnt == m_tgt) begin m_run = 0; nd = 1; end
      end
    end
    m_y = ny; m_done = nd;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input logic [PAT_W-1:0] p, input bit o, input logic [CNT_W-1:0] t);
    cfg_pattern = p; cfg_overlap = o; cfg_target = t;
  endtask

  task automatic drive(input bit st, input bit ab, input bit ai, input bit av);
    start = st; abort = ab; a = ai; a_vld = av;
    @(posedge clk);
    model_step(st, ab, ai, av);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    res = 1'b0; start = 0; abort = 0; a = 0; a_vld = 0;
    set_cfg('0, 0, '0);
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({y, done, busy, match_cnt, dbg_state} !== 13'd0) begin
      errors++;
      $display("FAIL reset y/done/busy/cnt/state got %b/%b/%b/%0d/%0d want all zero",
               y, done, busy, match_cnt, dbg_state);
    end
    @(negedge clk); res = 1'b1;
  endtask

  task automatic test_overlap();
    logic [11:0] s = 12'b1011_0111_1011;
    set_cfg(4'b1011, 1, 8'd0);
    drive(1, 0, 0, 0);
    exp_q = {8'd4, 8'd7, 8'd12};
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, s[11-i], 1);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL overlap bit=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i+1, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
      if (y === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0] != 8'(i+1)) begin
          errors++;
          $display("FAIL overlap_pulse y after bit %0d, want %0d", i+1,
                   (exp_q.size() == 0) ? 0 : int'(exp_q[0]));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (match_cnt !== 8'd3 || busy !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overlap_end cnt=%0d busy=%b missed=%0d want cnt=3 busy=1 missed=0",
               match_cnt, busy, exp_q.size());
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_nonoverlap();
    logic [11:0] s = 12'b1011_0111_1011;
    set_cfg(4'b1011, 0, 8'd0);
    drive(1, 0, 0, 0);
    exp_q = {8'd4, 8'd12};
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, s[11-i], 1);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL nonoverlap bit=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i+1, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
      if (y === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0] != 8'(i+1)) begin
          errors++;
          $display("FAIL nonoverlap_pulse y after bit %0d, want %0d", i+1,
                   (exp_q.size() == 0) ? 0 : int'(exp_q[0]));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (match_cnt !== 8'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL nonoverlap_end cnt=%0d missed=%0d want cnt=2 missed=0",
               match_cnt, exp_q.size());
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_target();
    logic [11:0] s = 12'b1011_0111_1011;
    int done_seen = 0;
    int done_bit = 0;
    set_cfg(4'b1011, 1, 8'd2);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, s[11-i], 1);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL target bit=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i+1, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
      if (done === 1'b1) begin
        done_seen++; done_bit = i + 1;
        checks++;
        if (y !== 1'b1) begin
          errors++;
          $display("FAIL target_y_with_done y=%b want 1", y);
        end
      end
    end
    checks++;
    if (done_seen != 1 || done_bit != 7 || match_cnt !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL target_end dones=%0d at bit %0d cnt=%0d busy=%b want 1 at 7 cnt=2 busy=0",
               done_seen, done_bit, match_cnt, busy);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] s = 4'b1011;
    set_cfg(4'b1011, 1, 8'd0);
    drive(1, 0, 0, 0);
    exp_q = {8'd4};
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(0, 0, 1'b1, 0);
      else            drive(0, 0, s[3-i/2], 1);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL gapped cyc=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
      if (y === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || i != 7) begin
          errors++;
          $display("FAIL gapped_pulse y at cycle %0d, want only at cycle 7", i);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL gapped_end missed=%0d cnt=%0d want missed=0 cnt=1", exp_q.size(), match_cnt);
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_abort();
    set_cfg(4'b1011, 1, 8'd1);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    drive(0, 1, 1, 1);
    checks++;
    if ({y, done, busy, match_cnt} !== 11'd0 || m_run || m_y) begin
      errors++;
      $display("FAIL abort y/done/busy/cnt got %b/%b/%b/%0d want 0/0/0/0", y, done, busy, match_cnt);
    end
    drive(0, 0, 0, 0);
    checks++;
    if (done !== 1'b0 || y !== 1'b0) begin
      errors++;
      $display("FAIL abort_after done=%b y=%b want 0/0", done, y);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] s = 7'b0111011;
    set_cfg(4'b1011, 1, 8'd0);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    checks++;
    if (y !== 1'b1 || match_cnt !== 8'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset y/cnt/busy got %b/%0d/%b want 1/1/1", y, match_cnt, busy);
    end
    #2 res = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({y, done, busy, match_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset y/done/busy/cnt got %b/%b/%b/%0d want 0/0/0/0",
               y, done, busy, match_cnt);
    end
    @(negedge clk); res = 1'b1;
    set_cfg(4'b1011, 0, 8'd0);
    drive(1, 0, 0, 0);
    exp_q = {8'd7};
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, s[6-i], 1);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL post_reset bit=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i+1, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
      if (y === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0] != 8'(i+1)) begin
          errors++;
          $display("FAIL post_reset_pulse y after bit %0d, want 7", i+1);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] s = 4'b1011;
    set_cfg(4'b1011, 1, 8'd1);
    drive(1, 0, 0, 0);
    set_cfg(4'b0000, 1, 8'd0);   // must not take effect mid-run
    for (int i = 0; i < 4; i++) drive(1, 0, s[3-i], 1);
    checks++;
    if (done !== 1'b1 || y !== 1'b1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL b2b_done done/y/cnt got %b/%b/%0d want 1/1/1", done, y, match_cnt);
    end
    drive(1, 0, 0, 1);            // start in DONE is ignored
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL b2b_idle busy/done/cnt got %b/%b/%0d want 0/0/1", busy, done, match_cnt);
    end
    drive(1, 0, 0, 0);            // start in IDLE with the new cfg
    checks++;
    if (busy !== 1'b1 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_restart busy/cnt got %b/%0d want 1/0", busy, match_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL b2b_zeros bit=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i+1, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_saturate();
    set_cfg(4'b1111, 1, 8'd0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 262; i++) begin
      drive(0, 0, 1, 1);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL saturate bit=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i+1, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
    end
    checks++;
    if (match_cnt !== 8'd255 || y !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL saturate_end cnt/y/busy got %0d/%b/%b want 255/1/1", match_cnt, y, busy);
    end
    drive(0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      set_cfg(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 8'($urandom_range(3, 0)));
      drive($urandom_range(3, 0) == 0, $urandom_range(29, 0) == 0,
            1'($urandom_range(1, 0)), $urandom_range(2, 0) != 0);
      checks++;
      if ({y, done, busy, match_cnt} !== {m_y, m_done, m_run, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL random cyc=%0d y/done/busy/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, y, done, busy, match_cnt, m_y, m_done, m_run, m_cnt);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_gapped();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
